aes_round_sequencer: RTL

//  Sequences the AES-128 processing core through one block: plaintext load, initial AddRoundKey,
//  NUM_ROUNDS-1 full rounds, and a final round without MixColumns. Drives round-key address and

---
 rtl/aes_round_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : AES-128 block sequencer: load, initial AddRoundKey, full rounds,
//            final round, then valid/ready hand-off of the ciphertext.
// Options  : AES_DECRYPT_EN adds mode/inv_sel and mirrored round-key order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer #(
   parameter int NUM_ROUNDS   = 10,
   parameter int RK_ADDR_W    = 4,
   parameter int ROUND_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 ready,
   output logic                 busy,
   output logic                 state_load,
   output logic                 state_en,
   output logic                 add_key_only,
   output logic                 last_round,
   output logic [RK_ADDR_W-1:0] rk_addr,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef AES_DECRYPT_EN
   input  logic                 mode,
   output logic                 inv_sel,
`endif
   output logic                 done
);

   localparam int c_cyc_w = $clog2(ROUND_CYCLES + 1);
   localparam logic [c_cyc_w-1:0]   c_last_cyc  = c_cyc_w'(ROUND_CYCLES - 1);
   localparam logic [RK_ADDR_W-1:0] c_nr        = RK_ADDR_W'(NUM_ROUNDS);
   localparam logic [RK_ADDR_W-1:0] c_last_full = RK_ADDR_W'(NUM_ROUNDS - 1);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_load  = 3'd1;
   localparam logic [2:0] c_st_ark   = 3'd2;
   localparam logic [2:0] c_st_round = 3'd3;
   localparam logic [2:0] c_st_final = 3'd4;
   localparam logic [2:0] c_st_hold  = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;
   logic [RK_ADDR_W-1:0] r_round_cnt;
   logic [c_cyc_w-1:0]   r_cyc_cnt;
   logic                 w_last_cyc;
   logic                 w_dec;

   assign w_last_cyc = (r_cyc_cnt == c_last_cyc);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle:  if (start) w_state_next = c_st_load;
            c_st_load:  w_state_next = c_st_ark;
            c_st_ark:   w_state_next = c_st_round;
            c_st_round: if (w_last_cyc && (r_round_cnt == c_last_full)) w_state_next = c_st_final;
            c_st_final: if (w_last_cyc) w_state_next = c_st_hold;
            c_st_hold:  if (out_ready) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
         endcase
      end
   end

   // Round and sub-cycle counters; the sub-cycle count restarts on every round boundary.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         r_round_cnt <= '0;
         r_cyc_cnt   <= '0;
      end else begin
         case (r_state)
            c_st_ark: begin
               r_round_cnt <= RK_ADDR_W'(1);
               r_cyc_cnt   <= '0;
            end
            c_st_round: begin
               if (w_last_cyc) begin
                  r_cyc_cnt <= '0;
                  if (r_round_cnt != c_last_full) r_round_cnt <= r_round_cnt + RK_ADDR_W'(1);
               end else begin
                  r_cyc_cnt <= r_cyc_cnt + c_cyc_w'(1);
               end
            end
            c_st_final: begin
               if (w_last_cyc) r_cyc_cnt <= '0;
               else            r_cyc_cnt <= r_cyc_cnt + c_cyc_w'(1);
            end
            default: begin
               r_round_cnt <= '0;
               r_cyc_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef AES_DECRYPT_EN
   logic r_mode;

   // Direction is captured at acceptance and ignored for the rest of the block.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         r_mode <= 1'b0;
      end else if ((r_state == c_st_idle) && start) begin
         r_mode <= mode;
      end else if ((r_state == c_st_hold) && out_ready) begin
         r_mode <= 1'b0;
      end
   end

   assign w_dec   = r_mode;
   assign inv_sel = r_mode;
`else
   assign w_dec = 1'b0;
`endif

   always_comb begin
      ready        = 1'b0;
      busy         = 1'b0;
      state_load   = 1'b0;
      state_en     = 1'b0;
      add_key_only = 1'b0;
      last_round   = 1'b0;
      rk_addr      = '0;
      out_valid    = 1'b0;
      done         = 1'b0;
      case (r_state)
         c_st_idle: ready = 1'b1;
         c_st_load: begin
            busy       = 1'b1;
            state_load = 1'b1;
         end
         c_st_ark: begin
            busy         = 1'b1;
            add_key_only = 1'b1;
            state_en     = 1'b1;
            rk_addr      = w_dec ? c_nr : '0;
         end
         c_st_round: begin
            busy     = 1'b1;
            state_en = w_last_cyc;
            rk_addr  = w_dec ? (c_nr - r_round_cnt) : r_round_cnt;
         end
         c_st_final: begin
            busy       = 1'b1;
            last_round = 1'b1;
            state_en   = w_last_cyc;
            rk_addr    = w_dec ? '0 : c_nr;
         end
         c_st_hold: begin
            out_valid = 1'b1;
            done      = out_ready;
         end
         default: ready = 1'b0;
      endcase
   end

endmodule

`default_nettype wire
